stack_drain: RTL and testbench
==============================

STACK_DRAIN -- requirements
Module: stack_drain

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the data width of stack_data and m_data.
REQ-002 Parameter CNTW, default 8, SHALL set the width of burst_len and count.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 start  input  1  SHALL request a drain; sampled only in IDLE.
REQ-006 burst_len  input  CNTW  SHALL give the number of words to pop, captured with start; 0 means drain until empty.
REQ-007 stack_empty  input  1  SHALL be the stack's empty flag.
REQ-008 stack_data  input  WIDTH  SHALL be the stack's read data, valid the cycle after a pop.
REQ-009 stack_pop  output  1  SHALL be a one-cycle pop request per word to the stack.
REQ-010 m_valid / m_ready / m_data  output / input / output, 1 / 1 / WIDTH  SHALL form the downstream valid-ready stream.
REQ-011 busy  output  1  SHALL be high in any state other than IDLE.
REQ-012 done  output  1  SHALL pulse for one cycle when a drain completes.
REQ-013 count  output  CNTW  SHALL hold the words delivered downstream in the current or last drain.

Function
REQ-014 The FSM SHALL have three states: IDLE, RUN and FLUSH.
REQ-015 IDLE to RUN SHALL occur on start=1; entry clears count and the pop counter and latches burst_len.
REQ-016 In RUN, stack_pop SHALL assert only when stack_empty=0, the pop limit is not yet reached, and (buffer occupancy + pops in flight) < 2.
REQ-017 stack_data SHALL be captured into a 2-entry output buffer exactly one cycle after each stack_pop.
REQ-018 Output data SHALL be emitted in capture order, so LIFO order is preserved.
REQ-019 RUN to FLUSH SHALL occur when the pops issued equal the latched burst_len (nonzero), or when stack_empty=1 is sampled with no pop in flight.
REQ-020 FLUSH to IDLE SHALL occur when the buffer is empty and no pop is in flight; done pulses in that transition cycle.
REQ-021 m_valid SHALL be high whenever the buffer is non-empty; m_data SHALL be the oldest entry and stay stable while m_valid=1 and m_ready=0.
REQ-022 A word SHALL transfer on m_valid and m_ready both high; count increments by 1 per transfer and saturates at 2^CNTW-1.
REQ-023 A simultaneous capture and transfer in one cycle SHALL leave occupancy unchanged, with no loss or duplication.
REQ-024 start received while not in IDLE SHALL be ignored.
REQ-025 burst_len greater than the stack contents SHALL end the drain by the empty rule in REQ-019, without error.
REQ-026 Steady-state throughput with m_ready=1 and a non-empty stack SHALL be one word per cycle; first m_valid SHALL appear 2 cycles after start.

Reset
REQ-027 Asserting rst low at any time, including mid-drain, SHALL force IDLE and set stack_pop, m_valid, busy and done to 0, count to 0, and the buffer to empty.
REQ-028 Any in-flight word at reset SHALL be discarded.

Configuration
REQ-029 With STACK_DRAIN_ABORT_EN defined, an input abort (1 bit) SHALL be present.
REQ-030 With STACK_DRAIN_ABORT_EN defined, abort=1 in RUN SHALL stop further pops and enter FLUSH; buffered and in-flight words are still delivered, then done pulses.
REQ-031 Without STACK_DRAIN_ABORT_EN, the abort port and its logic SHALL be absent.

Structure
REQ-032 A shared package SHALL hold the state encoding (IDLE=2'd0, RUN=2'd1, FLUSH=2'd2) and the WIDTH/CNTW defaults.
REQ-033 The 2-entry output buffer SHALL be a sub-module named drain_skid_buf.

Verification
REQ-034 Stack preloaded with ABCD, 1234, 2345; burst_len=0; m_ready=1 -> m_data 2345, 1234, ABCD on consecutive cycles, then done, count=3.
REQ-035 Same preload; burst_len=2 -> outputs 2345, 1234, done, count=2; ABCD remains in the stack.
REQ-036 m_ready toggled 1,0,0,1 during the drain -> m_data held while stalled, no pop leaves more than 2 words outstanding, all 3 words delivered in order.
REQ-037 Stack empty at start -> no stack_pop, done within 3 cycles, count=0.
REQ-038 rst pulsed low after the first transfer -> immediately busy=0, m_valid=0, count=0; a new start drains the remaining words.
REQ-039 With STACK_DRAIN_ABORT_EN defined, a 10-word stack and abort after 3 pops -> exactly 3 words delivered, done, count=3.

Source files
------------

// File: rtl/stack_drain_pkg.sv
// Shared definitions for the stack drain engine.
//   - state_e       : FSM encoding (IDLE=0, RUN=1, FLUSH=2)
//   - WIDTH_DEFAULT : default data width of the stack / output stream
//   - CNTW_DEFAULT  : default width of burst length and delivered-word count
package stack_drain_pkg;

    localparam int unsigned WIDTH_DEFAULT = 32;
    localparam int unsigned CNTW_DEFAULT  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_e;

endpackage

// File: rtl/drain_skid_buf.sv
// Two-entry in-order buffer sitting between the stack read port and the
// downstream valid/ready stream. Entries leave in the order they arrived.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset (empties the buffer)
//   push_i/data_i : write one entry this cycle
//   pop_i         : downstream accepted the head entry this cycle
//   valid_o       : buffer holds at least one entry
//   data_o        : oldest entry (stable until popped)
//   cnt_o         : current occupancy, 0..2
module drain_skid_buf #(
    parameter int unsigned Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [Width-1:0] data_o,
    output logic [1:0]       cnt_o
);

    logic [Width-1:0] mem_q [2];
    logic [Width-1:0] mem_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             do_pop;
    logic             do_push;

    assign do_pop  = pop_i && (cnt_q != 2'd0);
    // A push into a full buffer is only legal when the head leaves in the same cycle.
    assign do_push = push_i && ((cnt_q != 2'd2) || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign valid_o = (cnt_q != 2'd0);
    assign data_o  = mem_q[rd_ptr_q];
    assign cnt_o   = cnt_q;

endmodule

// File: rtl/stack_drain.sv
// Stack drain engine: pops words from a stack (read data valid one cycle
// after each pop) and streams them downstream over valid/ready, preserving
// LIFO order. A drain is started with start/burst_len (0 = until empty).
// Optional feature macro: STACK_DRAIN_ABORT_EN adds an abort input that stops
// popping and flushes the words already requested.
// Ports:
//   clk, rst              : clock, asynchronous active-low reset
//   start, burst_len      : drain request and word limit (sampled in IDLE)
//   abort                 : stop popping early (STACK_DRAIN_ABORT_EN only)
//   stack_empty           : stack empty flag
//   stack_data            : stack read data, valid the cycle after stack_pop
//   stack_pop             : one-cycle pop request per word
//   m_valid/m_ready/m_data: downstream stream
//   busy, done            : not-idle flag, one-cycle completion pulse
//   count                 : words delivered in the current/last drain (saturating)
module stack_drain
    import stack_drain_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT,
    parameter int unsigned CNTW  = CNTW_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNTW-1:0]  burst_len,
`ifdef STACK_DRAIN_ABORT_EN
    input  logic             abort,
`endif
    input  logic             stack_empty,
    input  logic [WIDTH-1:0] stack_data,
    output logic             stack_pop,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             busy,
    output logic             done,
    output logic [CNTW-1:0]  count
);

    state_e          state_q, state_d;
    logic [CNTW-1:0] len_q, len_d;
    logic [CNTW-1:0] pop_cnt_q, pop_cnt_d;
    logic [CNTW-1:0] count_q, count_d;
    logic            inflight_q, inflight_d;

    logic [1:0]      buf_cnt;
    logic            xfer;
    logic [1:0]      occ_after;
    logic            room;
    logic            limit_hit;
    logic            abort_req;

    assign xfer = m_valid & m_ready;

    // Occupancy is judged after this cycle's transfer so that a word leaving
    // frees its slot immediately; this is what sustains one word per cycle.
    assign occ_after = buf_cnt - {1'b0, xfer};
    assign room      = (occ_after + {1'b0, inflight_q}) < 2'd2;
    assign limit_hit = (len_q != '0) && (pop_cnt_q == len_q);

`ifdef STACK_DRAIN_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        pop_cnt_d = pop_cnt_q;
        count_d   = count_q;
        stack_pop = 1'b0;
        done      = 1'b0;

        if (xfer && (count_q != {CNTW{1'b1}})) begin
            count_d = count_q + CNTW'(1);
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = RUN;
                    len_d     = burst_len;
                    pop_cnt_d = '0;
                    count_d   = '0;
                end
            end
            RUN: begin
                if (abort_req || limit_hit) begin
                    state_d = FLUSH;
                end else if (stack_empty && !inflight_q) begin
                    state_d = FLUSH;
                end else if (!stack_empty && room) begin
                    stack_pop = 1'b1;
                    pop_cnt_d = pop_cnt_q + CNTW'(1);
                end
            end
            FLUSH: begin
                if ((buf_cnt == 2'd0) && !inflight_q) begin
                    state_d = IDLE;
                    done    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        inflight_d = stack_pop;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            len_q      <= '0;
            pop_cnt_q  <= '0;
            count_q    <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            pop_cnt_q  <= pop_cnt_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
        end
    end

    // Capture happens exactly one cycle after the pop, when stack_data is valid.
    drain_skid_buf #(
        .Width (WIDTH)
    ) u_skid_buf (
        .clk_i   (clk),
        .rst_ni  (rst),
        .push_i  (inflight_q),
        .data_i  (stack_data),
        .pop_i   (xfer),
        .valid_o (m_valid),
        .data_o  (m_data),
        .cnt_o   (buf_cnt)
    );

    assign busy  = (state_q != IDLE);
    assign count = count_q;

endmodule

// File: tb/tb_stack_drain.sv
// Self-checking bench for stack_drain: a behavioural stack model feeds the
// DUT, expected words are queued when a drain is launched and compared as the
// DUT hands them downstream. Define STACK_DRAIN_ABORT_EN to exercise abort.
module tb_stack_drain;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNTW  = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [CNTW-1:0]  burst_len = '0;
    logic             stack_empty;
    logic [WIDTH-1:0] stack_data;
    logic             stack_pop;
    logic             m_valid;
    logic             m_ready = 1'b1;
    logic [WIDTH-1:0] m_data;
    logic             busy;
    logic             done;
    logic [CNTW-1:0]  count;
`ifdef STACK_DRAIN_ABORT_EN
    logic             abort = 1'b0;
`endif

    stack_drain #(
        .WIDTH (WIDTH),
        .CNTW  (CNTW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .burst_len   (burst_len),
`ifdef STACK_DRAIN_ABORT_EN
        .abort       (abort),
`endif
        .stack_empty (stack_empty),
        .stack_data  (stack_data),
        .stack_pop   (stack_pop),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .busy        (busy),
        .done        (done),
        .count       (count)
    );

    always #5 clk = ~clk;

    // Stack model: registered read, top of stack at stk_sp-1.
    logic [WIDTH-1:0] stk_mem [16];
    int               stk_sp = 0;
    logic [WIDTH-1:0] ld_mem [16];
    int               ld_n = 0;
    logic             ld_go = 1'b0;

    always @(posedge clk) begin
        if (ld_go) begin
            stk_mem <= ld_mem;
            stk_sp  <= ld_n;
        end else if (stack_pop && (stk_sp > 0)) begin
            stack_data <= stk_mem[stk_sp-1];
            stk_sp     <= stk_sp - 1;
        end
    end
    assign stack_empty = (stk_sp == 0);

    int               n_cmp = 0;
    int               n_err = 0;
    logic [WIDTH-1:0] exp_q [$];
    int               pop_total = 0;
    int               xfer_total = 0;
    int               max_out = 0;
    int               done_cnt = 0;
    logic [CNTW-1:0]  count_at_done = '0;
    logic             last_valid = 1'b0;
    logic             last_busy = 1'b0;
    logic             last_xfer = 1'b0;
    logic             prev_stall = 1'b0;
    logic [WIDTH-1:0] prev_data = '0;
    int               cyc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Observe the DUT on the falling edge, where every output is settled.
    task automatic sample();
        logic [WIDTH-1:0] e;
        if (prev_stall) begin
            check("hold_valid", 64'(m_valid), 64'd1);
            check("hold_data", 64'(m_data), 64'(prev_data));
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        last_valid = m_valid;
        last_busy  = busy;
        last_xfer  = m_valid && m_ready;
        if (last_xfer) begin
            xfer_total++;
            check("sb_word_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("m_data", 64'(m_data), 64'(e));
            end
        end
        if (stack_pop) begin
            pop_total++;
            check("pop_when_nonempty", 64'(stack_empty), 64'd0);
        end
        if ((pop_total - xfer_total) > max_out) max_out = pop_total - xfer_total;
        if (done) begin
            done_cnt++;
            count_at_done = count;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int n);
        for (int i = 0; i < 16; i++) ld_mem[i] = 32'h1000 + 32'(i);
        if (n == 3) begin
            ld_mem[0] = 32'hABCD;
            ld_mem[1] = 32'h1234;
            ld_mem[2] = 32'h2345;
        end
        ld_n  = n;
        ld_go = 1'b1;
        cycle();
        ld_go = 1'b0;
    endtask

    // Expected LIFO order: top k words of an n-word preload.
    task automatic push_lifo(input int n, input int k);
        for (int i = n - 1; i >= n - k; i--) exp_q.push_back(ld_mem[i]);
    endtask

    task automatic clr();
        pop_total  = 0;
        xfer_total = 0;
        max_out    = 0;
    endtask

    task automatic start_drain(input logic [CNTW-1:0] len);
        burst_len = len;
        start     = 1'b1;
        cycle();
        start     = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, output int c);
        int d;
        d = done_cnt;
        c = budget + 1;
        for (int i = 0; i < budget; i++) begin
            cycle();
            if (done_cnt != d) begin
                c = i + 1;
                break;
            end
        end
        check(tag, 64'(done_cnt - d), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end

    initial begin
        // Reset values
        repeat (2) cycle();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(m_valid), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_pop", 64'(stack_pop), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        rst = 1'b1;
        cycle();

        // Full drain, burst_len = 0, always ready
        load(3);
        push_lifo(3, 3);
        clr();
        start_drain(8'd0);
        cycle();
        check("t1_valid_c1", 64'(last_valid), 64'd0);
        cycle();
        check("t1_valid_c2", 64'(last_valid), 64'd0);
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("t1_valid_stream", 64'(last_valid), 64'd1);
        end
        wait_done("t1_done", 20, cyc);
        check("t1_count", 64'(count_at_done), 64'd3);
        check("t1_sb_empty", 64'(exp_q.size()), 64'd0);
        cycle();
        check("t1_idle", 64'(last_busy), 64'd0);

        // Limited burst; a start while busy must be ignored
        load(3);
        push_lifo(3, 2);
        clr();
        start_drain(8'd2);
        burst_len = 8'd0;
        start     = 1'b1;
        cycle();
        start     = 1'b0;
        wait_done("t2_done", 20, cyc);
        check("t2_count", 64'(count_at_done), 64'd2);
        check("t2_sb_empty", 64'(exp_q.size()), 64'd0);
        check("t2_left", 64'(stk_sp), 64'd1);
        check("t2_left_word", 64'(stk_mem[0]), 64'hABCD);
        cycle();
        cycle();
        check("t2_no_restart", 64'(last_busy), 64'd0);

        // Back-pressure: ready 1,0,0,1 around the first words
        load(3);
        push_lifo(3, 3);
        clr();
        start_drain(8'd0);
        begin
            int d;
            d = done_cnt;
            for (int i = 0; (i < 30) && (done_cnt == d); i++) begin
                m_ready = ((i == 3) || (i == 4)) ? 1'b0 : 1'b1;
                cycle();
            end
            check("t3_done", 64'(done_cnt - d), 64'd1);
        end
        m_ready = 1'b1;
        check("t3_count", 64'(count_at_done), 64'd3);
        check("t3_sb_empty", 64'(exp_q.size()), 64'd0);
        check("t3_outstanding_le2", 64'(max_out <= 2), 64'd1);

        // Empty stack at start
        load(0);
        clr();
        start_drain(8'd0);
        wait_done("t4_done", 10, cyc);
        check("t4_done_within3", 64'(cyc <= 3), 64'd1);
        check("t4_no_pop", 64'(pop_total), 64'd0);
        check("t4_count", 64'(count_at_done), 64'd0);

        // Reset after the first transfer, then drain the rest
        load(6);
        push_lifo(6, 1);
        clr();
        start_drain(8'd0);
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (last_xfer) break;
        end
        check("t5_first_xfer", 64'(last_xfer), 64'd1);
        rst = 1'b0;
        #1;
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_valid", 64'(m_valid), 64'd0);
        check("t5_count", 64'(count), 64'd0);
        check("t5_pop", 64'(stack_pop), 64'd0);
        check("t5_done", 64'(done), 64'd0);
        cycle();
        rst = 1'b1;
        cycle();
        exp_q.delete();
        push_lifo(3, 3);
        clr();
        start_drain(8'd0);
        wait_done("t5_redrain_done", 20, cyc);
        check("t5_redrain_count", 64'(count_at_done), 64'd3);
        check("t5_sb_empty", 64'(exp_q.size()), 64'd0);
        check("t5_stack_empty", 64'(stk_sp), 64'd0);

`ifdef STACK_DRAIN_ABORT_EN
        // Abort after three pops of a ten-word stack
        load(10);
        push_lifo(10, 3);
        clr();
        start_drain(8'd0);
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (pop_total >= 3) break;
        end
        abort = 1'b1;
        wait_done("t6_done", 20, cyc);
        abort = 1'b0;
        check("t6_pops", 64'(pop_total), 64'd3);
        check("t6_count", 64'(count_at_done), 64'd3);
        check("t6_sb_empty", 64'(exp_q.size()), 64'd0);
        check("t6_left", 64'(stk_sp), 64'd7);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
